regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump_pkg.sv | 17 +
 rtl/regfile_dump.sv | 107 ++++++++++
 tb/tb_regfile_dump.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared register-file constants and dump FSM state encoding
//
// Purpose : constants and types shared by the register-file dump logic.
// Contents: NUM_REGS, ADDR_W, state_t (IDLE=0, CAPTURE=1, SEND=2, FINISH=3).
package regfile_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - streams an inclusive, wrapping range of register-file words
//
// Purpose: on start, walks the register-file read port from first_addr to
//          last_addr (modulo 32) and presents each word on a valid/ready stream.
// Ports  : clk, rst        - clock, asynchronous active-high reset
//          start, abort    - dump request / cancel
//          first_addr,
//          last_addr       - inclusive range, latched when start is accepted
//          rf_rd_addr,
//          rf_rd_data      - combinational register-file read port
//          out_valid,
//          out_ready,
//          out_data,
//          out_index,
//          out_last        - word stream
//          busy, done      - status; done pulses one cycle after the last word
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [N-1:0]      rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_last_addr;
  logic [N-1:0]      r_out_data;
  logic [ADDR_W-1:0] r_out_index;
  logic              r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_addr <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start wins over a coincident abort here; abort has nothing to cancel.
          if (start) begin
            r_cnt       <= first_addr;
            r_last_addr <= last_addr;
            r_state     <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_out_data  <= rf_rd_data;
            r_out_index <= r_cnt;
            r_out_last  <= (r_cnt == r_last_addr);
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // abort is checked first so a coincident handshake is not a transfer.
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (out_ready) begin
            if (r_out_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_cnt   <= r_cnt + 1'b1;  // 5-bit wrap 31->0 is intended
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state register, so they clear
  // together with it on an asynchronous reset.
  assign out_valid  = (r_state == ST_SEND);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign rf_rd_addr = r_cnt;
  assign out_data   = r_out_data;
  assign out_index  = r_out_index;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump
module tb_regfile_dump;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [4:0]   first_addr;
  logic [4:0]   last_addr;
  logic [4:0]   rf_rd_addr;
  logic [N-1:0] rf_rd_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [4:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         done;

  regfile_dump #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rf [32];
  assign rf_rd_data = rf[rf_rd_addr];

  typedef struct {
    int           idx;
    logic [N-1:0] data;
    bit           last;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected words of a dump: first..last stepping by one modulo 32.
  task automatic push_expected(input int f, input int l);
    int cnt;
    exp_t e;
    cnt = ((l - f + 32) % 32) + 1;
    for (int i = 0; i < cnt; i++) begin
      e.idx  = (f + i) % 32;
      e.data = rf[e.idx];
      e.last = (i == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  bit           done_due;
  bit           prev_stall;
  logic [N-1:0] h_data;
  logic [4:0]   h_idx;
  logic         h_last;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      done_due   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("done_pulse", done, done_due);
      done_due = 1'b0;
      if (prev_stall) begin
        check("valid_held", out_valid, 1);
        if (out_valid) begin
          check("stall_data", out_data, h_data);
          check("stall_index", out_index, h_idx);
          check("stall_last", out_last, h_last);
        end
      end
      prev_stall = out_valid && !out_ready && !abort;
      h_data = out_data;
      h_idx  = out_index;
      h_last = out_last;
      if (out_valid && out_ready && !abort) begin
        check("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("xfer_index", out_index, e.idx[4:0]);
          check("xfer_data", out_data, e.data);
          check("xfer_last", out_last, e.last);
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;  // 0: always 1, 1: 0,0,1 repeating, 2: random
  int ready_ph   = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ready_ph == 2);
          ready_ph  = (ready_ph + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_dump(input int f, input int l, input bit chk_rate, input bit spurious);
    int cnt;
    int cycles;
    cnt = ((l - f + 32) % 32) + 1;
    push_expected(f, l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    @(posedge clk);
    #1;
    start      = 1'b0;
    first_addr = 5'($urandom);
    last_addr  = 5'($urandom);
    check("busy_after_start", busy, 1);
    check("no_valid_in_capture", out_valid, 0);
    @(posedge clk);
    #1;
    check("first_valid_latency", out_valid, 1);
    cycles = 1;
    while (cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!busy) break;
      start      = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      first_addr = 5'($urandom);
      last_addr  = 5'($urandom);
    end
    start = 1'b0;
    check("dump_finished", busy, 0);
    if (chk_rate) check("dump_cycles", cycles, 2 * cnt + 1);
  endtask

  task automatic run_abort(input int f, input int l);
    int cnt;
    int sends;
    int guard;
    cnt = ((l - f + 32) % 32) + 1;
    push_expected(f, l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    sends = 0;
    guard = 0;
    while (sends < 3 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
      if (out_valid) sends++;
    end
    check("abort_reached_third_send", sends, 3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_words_left", exp_q.size(), cnt - 2);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
  endtask

  task automatic run_reset_mid();
    push_expected(12, 15);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = 5'd12;
    last_addr  = 5'd15;
    @(posedge clk);
    #2;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", rf_rd_addr, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stays_idle", busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : N'(32'h100 + i);
    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_data", out_data, 0);
    check("reset_index", out_index, 0);
    check("reset_last", out_last, 0);
    check("reset_addr", rf_rd_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ready_mode = 0;
    run_dump(0, 31, 1, 0);
    run_dump(30, 1, 1, 0);
    ready_mode = 1;
    ready_ph   = 0;
    run_dump(5, 8, 0, 0);
    ready_mode = 0;
    run_dump(7, 7, 1, 1);
    run_abort(10, 17);
    run_dump(3, 4, 1, 0);
    run_reset_mid();
    run_dump(20, 22, 1, 0);

    for (int i = 0; i < 32; i++) rf[i] = N'($urandom);
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
